// File: rtl/serial_frame_receiver.sv
// rtl/serial_frame_receiver.sv - serial bit receiver controlling a 5-bit bit-period counter (optional parity via RX_PARITY_EN)
module serial_frame_receiver #(
    parameter int DATA_W    = 8,
    parameter int SAMPLE_PT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx,
    input  logic [4:0]        count,
    input  logic              complete,
    output logic              cnt_run,
    output logic [DATA_W-1:0] data,
    output logic              data_valid,
    input  logic              data_ready,
    output logic              frame_err,
    output logic              overrun
);

    localparam int         IDX_W      = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [4:0] SAMPLE_CNT = 5'(SAMPLE_PT);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

`ifdef RX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t            state_q, state_d;
    logic              sync1_q, rx_s_q;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              cnt_run_q, cnt_run_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              ferr_q, ferr_d;
    logic              ovr_q, ovr_d;
    logic              sample;
    logic              frame_ok;
`ifdef RX_PARITY_EN
    logic              perr_q, perr_d;
`endif

    assign sample = (count == SAMPLE_CNT);

`ifdef RX_PARITY_EN
    assign frame_ok = rx_s_q && !perr_q;
`else
    assign frame_ok = rx_s_q;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q   <= 1'b1;
            rx_s_q    <= 1'b1;
            state_q   <= S_IDLE;
            shift_q   <= '0;
            idx_q     <= '0;
            cnt_run_q <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
`ifdef RX_PARITY_EN
            perr_q    <= 1'b0;
`endif
        end else begin
            sync1_q   <= rx;
            rx_s_q    <= sync1_q;
            state_q   <= state_d;
            shift_q   <= shift_d;
            idx_q     <= idx_d;
            cnt_run_q <= cnt_run_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
`ifdef RX_PARITY_EN
            perr_q    <= perr_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        idx_d     = idx_q;
        cnt_run_d = cnt_run_q;
        data_d    = data_q;
        valid_d   = valid_q;
        ferr_d    = 1'b0;
        ovr_d     = 1'b0;
`ifdef RX_PARITY_EN
        perr_d    = perr_q;
`endif
        if (valid_q && data_ready) begin
            valid_d = 1'b0;
        end
        case (state_q)
            S_IDLE: begin
                cnt_run_d = 1'b0;
                idx_d     = '0;
`ifdef RX_PARITY_EN
                perr_d    = 1'b0;
`endif
                if (!rx_s_q) begin
                    state_d   = S_START;
                    cnt_run_d = 1'b1;
                end
            end
            S_START: begin
                if (sample && rx_s_q) begin
                    state_d   = S_IDLE;
                    cnt_run_d = 1'b0;
                end else if (complete) begin
                    state_d = S_DATA;
                    idx_d   = '0;
                end
            end
            S_DATA: begin
                if (sample) begin
                    shift_d = {rx_s_q, shift_q[DATA_W-1:1]};
                end
                if (complete) begin
                    if (idx_q == LAST_IDX) begin
`ifdef RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
`ifdef RX_PARITY_EN
            S_PARITY: begin
                // Even parity: data ones plus the parity bit must be even.
                if (sample) begin
                    perr_d = (^shift_q) ^ rx_s_q;
                end
                if (complete) begin
                    state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                // Leave before the period ends so a back-to-back start edge is seen.
                if (sample) begin
                    state_d   = S_IDLE;
                    cnt_run_d = 1'b0;
                    if (frame_ok) begin
                        if (!valid_q || data_ready) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                        end else begin
                            ovr_d = 1'b1;
                        end
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d   = S_IDLE;
                cnt_run_d = 1'b0;
            end
        endcase
    end

    assign cnt_run    = cnt_run_q;
    assign data       = data_q;
    assign data_valid = valid_q;
    assign frame_err  = ferr_q;
    assign overrun    = ovr_q;

endmodule

// File: tb/tb_serial_frame_receiver.sv
// tb/tb_serial_frame_receiver.sv - self-checking bench for serial_frame_receiver with a model of the 5-bit counter
module tb_serial_frame_receiver;

    localparam int BIT_CYC = 32;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rx = 1'b1;
    logic [4:0] count;
    logic       complete;
    logic       cnt_run;
    logic [7:0] data;
    logic       data_valid;
    logic       data_ready = 1'b1;
    logic       frame_err;
    logic       overrun;

    int checks = 0;
    int failures = 0;

    int         n_valid_cyc = 0, n_ferr = 0, n_ovr = 0, n_both = 0, n_cmp = 0, n_unstable = 0;
    logic [7:0] last_data = 8'h00;
    logic       prev_valid = 1'b0, prev_ready = 1'b0;
    logic [7:0] prev_data = 8'h00;

    serial_frame_receiver #(.DATA_W(8), .SAMPLE_PT(15)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .count      (count),
        .complete   (complete),
        .cnt_run    (cnt_run),
        .data       (data),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .frame_err  (frame_err),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    // Bit-period counter: held at 0 while cnt_run is low, wraps every 32 cycles.
    always @(posedge clk) begin
        if (!cnt_run) count <= 5'd0;
        else          count <= count + 5'd1;
    end
    assign complete = cnt_run && (count == 5'd31);

    always @(negedge clk) begin
        if (data_valid) begin
            n_valid_cyc = n_valid_cyc + 1;
            last_data   = data;
        end
        if (frame_err) n_ferr = n_ferr + 1;
        if (overrun) n_ovr = n_ovr + 1;
        if (frame_err && overrun) n_both = n_both + 1;
        if (complete) n_cmp = n_cmp + 1;
        if (prev_valid && !prev_ready && data_valid && (data != prev_data)) n_unstable = n_unstable + 1;
        prev_valid = data_valid;
        prev_ready = data_ready;
        prev_data  = data;
    end

    task automatic check(input string name, input int got, input int exp);
        checks = checks + 1;
        if (got != exp) begin
            failures = failures + 1;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic hold_bit(input logic b);
        rx = b;
        repeat (BIT_CYC) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input logic par);
        hold_bit(1'b0);
        for (int i = 0; i < 8; i++) hold_bit(d[i]);
`ifdef RX_PARITY_EN
        hold_bit(par);
`else
        if (par === 1'bx) hold_bit(1'b1);
`endif
        hold_bit(stop);
        rx = 1'b1;
    endtask

    typedef struct {
        logic [7:0] d;
        logic       stop;
        logic       par;
        int         exp_valid_cyc;
        logic [7:0] exp_data;
        int         exp_ferr;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int v0, f0, o0, c0;

        vecs[0] = '{8'hA5, 1'b1, 1'b0, 1, 8'hA5, 0};
        vecs[1] = '{8'h3C, 1'b0, 1'b0, 0, 8'h00, 1};
        vecs[2] = '{8'h00, 1'b1, 1'b0, 1, 8'h00, 0};
        vecs[3] = '{8'hFF, 1'b1, 1'b0, 1, 8'hFF, 0};
        vecs[4] = '{8'h07, 1'b1, 1'b1, 1, 8'h07, 0};
`ifdef RX_PARITY_EN
        vecs[5] = '{8'h07, 1'b1, 1'b0, 0, 8'h00, 1};
`else
        vecs[5] = '{8'h81, 1'b1, 1'b0, 1, 8'h81, 0};
`endif

        repeat (3) @(negedge clk);
        check("reset_cnt_run", cnt_run, 0);
        check("reset_data", data, 0);
        check("reset_valid", data_valid, 0);
        check("reset_ferr", frame_err, 0);
        check("reset_ovr", overrun, 0);
        reset = 1'b1;
        repeat (5) @(negedge clk);

        for (int k = 0; k < 6; k++) begin
            v0 = n_valid_cyc; f0 = n_ferr; o0 = n_ovr;
            data_ready = 1'b1;
            send_frame(vecs[k].d, vecs[k].stop, vecs[k].par);
            repeat (20) @(negedge clk);
            check($sformatf("vec%0d_valid_cycles", k), n_valid_cyc - v0, vecs[k].exp_valid_cyc);
            if (vecs[k].exp_valid_cyc != 0)
                check($sformatf("vec%0d_data", k), last_data, vecs[k].exp_data);
            check($sformatf("vec%0d_ferr", k), n_ferr - f0, vecs[k].exp_ferr);
            check($sformatf("vec%0d_ovr", k), n_ovr - o0, 0);
            check($sformatf("vec%0d_cnt_run_idle", k), cnt_run, 0);
        end

        // Glitch: start edge that is gone by the mid-period sample.
        v0 = n_valid_cyc; c0 = n_cmp; f0 = n_ferr;
        rx = 1'b0;
        repeat (10) @(negedge clk);
        rx = 1'b1;
        repeat (60) @(negedge clk);
        check("glitch_cnt_run", cnt_run, 0);
        check("glitch_no_complete", n_cmp - c0, 0);
        check("glitch_valid", n_valid_cyc - v0, 0);
        check("glitch_ferr", n_ferr - f0, 0);

        // Back-to-back frames with downstream stalled.
        o0 = n_ovr;
        data_ready = 1'b0;
        send_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0);
        repeat (10) @(negedge clk);
        check("ovr_pulse", n_ovr - o0, 1);
        check("ovr_held_valid", data_valid, 1);
        check("ovr_held_data", data, 8'h11);
        data_ready = 1'b1;
        @(negedge clk);
        check("ovr_valid_cleared", data_valid, 0);
        check("ovr_data_stable", n_unstable, 0);

        // Reset asserted mid-frame, during bit 4 of 0xFF.
        hold_bit(1'b0);
        for (int i = 0; i < 4; i++) hold_bit(1'b1);
        repeat (BIT_CYC / 2) @(negedge clk);
        check("pre_reset_cnt_run", cnt_run, 1);
        reset = 1'b0;
        #1;
        check("mid_reset_cnt_run", cnt_run, 0);
        check("mid_reset_valid", data_valid, 0);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        repeat (40) @(negedge clk);
        v0 = n_valid_cyc;
        send_frame(8'h5A, 1'b1, 1'b0);
        repeat (20) @(negedge clk);
        check("post_reset_valid_cycles", n_valid_cyc - v0, 1);
        check("post_reset_data", last_data, 8'h5A);

        check("ferr_ovr_never_together", n_both, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_frame_receiver.md
# serial_frame_receiver

Bit-level receiver for the demo receiver board. It detects a start edge on the asynchronous serial line and takes the five-bit bit-period counter out of reset. It samples each bit at mid-period using the counter's `count` and `complete` outputs, and delivers assembled words downstream through a valid/ready handshake. The block sits directly upstream of, and controls, the five-bit counter: it drives the counter's reset and consumes the counter's outputs.

## Interface
- `DATA_W`, 8: data bits per frame, LSB first.
- `SAMPLE_PT`, 15: `count` value at which the line is sampled. Legal range is 1..30.

- `clk`  in  1: system clock.
- `reset`  in  1: asynchronous, active-low reset.
- `rx`  in  1: serial line, idle high, asynchronous to `clk`.
- `count`  in  5: bit-period counter value.
- `complete`  in  1: one-cycle pulse from the counter when `count` wraps 31→0, marking the end of a bit period.
- `cnt_run`  out  1: drives the counter's active-low reset. 0 holds the counter at 0.
- `data`  out  DATA_W: received word.
- `data_valid`  out  1: `data` is held until accepted.
- `data_ready`  in  1: downstream accepts `data` when `data_valid` && `data_ready`.
- `frame_err`  out  1: one-cycle pulse for a bad stop bit (or bad parity).
- `overrun`  out  1: one-cycle pulse when a good frame is dropped.

## Operation
- Synchronizer:
  - `rx` passes through two flops to produce `rx_s`.
  - Both flops reset to 1.
- FSM states are IDLE, START, DATA, PARITY (only with the macro defined), and STOP.
- IDLE:
  - `cnt_run`=0.
  - When `rx_s`==0, go to START and set `cnt_run`=1 on the same edge.
- START:
  - At `count`==`SAMPLE_PT`: if `rx_s`==1, this is a false start. Return to IDLE and set `cnt_run`=0.
  - Otherwise wait for `complete`, then go to DATA with bit index 0.
- DATA:
  - At `count`==`SAMPLE_PT`, shift `rx_s` into the MSB of the shift register (right shift). After DATA_W samples, bit 0 holds the first bit received.
  - On `complete`: if the index is DATA_W-1, go to PARITY or STOP; otherwise increment the index.
- STOP:
  - At `count`==`SAMPLE_PT`, sample the stop bit, then go immediately to IDLE with `cnt_run`=0. The FSM does not wait for `complete`, so a back-to-back start bit is caught.
  - Stop bit = 1 and no parity error: good frame.
  - Otherwise pulse `frame_err` and discard the frame.
- Output register, on a good frame:
  - If `data_valid`==0, or `data_valid`&&`data_ready` in this cycle: load `data` and set `data_valid`=1.
  - Otherwise pulse `overrun`. `data` and `data_valid` are unchanged and the new frame is lost.
- `data_valid` clears on a handshake cycle in which no new frame loads.
- Reset outputs:
  - `cnt_run`=0, `data`=0, `data_valid`=0, `frame_err`=0, `overrun`=0.
  - FSM in IDLE, shift register and index at 0.
- Reset asserted mid-frame: the frame is abandoned and all state returns to reset values immediately. The next frame needs a fresh falling edge seen after reset is released.
- `complete` is ignored in IDLE and STOP.
- `count` ==`SAMPLE_PT` is ignored in IDLE.

## Timing
- `rx` falling edge to `rx_s` low: 2 `clk` edges.
- `rx_s` low to `cnt_run` high: 1 edge.
- Bit period is 32 `clk` cycles, as set by the counter.
- Sampling happens on the edge where `count`==`SAMPLE_PT`.
- `data_valid` rises, or `frame_err`/`overrun` pulses, on the edge following the stop-bit sample.
- `cnt_run` falls on the same edge.
- `data` is stable while `data_valid`=1 and `data_ready`=0.
- Handshake and load can occur in the same cycle with no bubble.
- `frame_err` and `overrun` are each exactly one cycle wide and never assert together.

## Configuration
- `RX_PARITY_EN` defined:
  - The PARITY state follows DATA.
  - One even-parity bit is sampled at `SAMPLE_PT`, and the FSM goes to STOP on `complete`.
  - A parity mismatch makes the frame bad: `frame_err` pulses after the stop sample and the frame is discarded.
  - A frame is 1+DATA_W+1+1 bits.
- `RX_PARITY_EN` undefined:
  - No PARITY state, and DATA goes straight to STOP.
  - A frame is 1+DATA_W+1 bits.

## Test plan
- Send 0xA5 at 32 clk/bit with `data_ready`=1. Required: `data`=0xA5, `data_valid` high for 1 cycle, `cnt_run` low after the stop sample, and no `frame_err`.
- Hold `rx` low for 10 cycles, then high (glitch). Required: the START sample at `count`==15 sees 1, the FSM returns to IDLE, `cnt_run`=0, and `data_valid` stays 0.
- Send 0x3C with the stop bit driven 0. Required: one-cycle `frame_err` pulse and `data_valid` stays 0.
- With `data_ready`=0, send 0x11 then 0x22 back-to-back. Required: `data`=0x11 is held, `overrun` pulses once after the second stop bit, and raising `data_ready` clears `data_valid`.
- Assert `reset` during bit 4 of 0xFF, release it, then send 0x5A. Required: immediate `cnt_run`=0 and `data_valid`=0 during reset, and 0x5A is received correctly afterwards.
- Parity build (`RX_PARITY_EN` defined): 0x07 with parity bit 1 gives `data`=0x07. 0x07 with parity bit 0 gives a `frame_err` pulse and no `data_valid`.
